// File: rtl/event_trig_pkg.sv
// Shared constants for the event_trigger_out notifier: event bit map, ack bits,
// host endpoint addresses and the post-reset warm-up states of the counter monitor.
package event_trig_pkg;

  localparam int unsigned NUM_EVENTS      = 16;
  localparam int unsigned NUM_BUTTONS     = 4;
  localparam int unsigned EVT_PRESS_LSB   = 0;
  localparam int unsigned EVT_RELEASE_LSB = 4;
  localparam int unsigned EVT_CROSS       = 8;
  localparam int unsigned EVT_WRAP        = 9;
  localparam int unsigned ACK_LOST_CLR    = 15;

  localparam logic [7:0] EP_TRIG_OUT   = 8'h60;
  localparam logic [7:0] EP_STATUS     = 8'h3B;
  localparam logic [7:0] EP_LOST_CNT   = 8'h3C;
  localparam logic [7:0] EP_ACK        = 8'h41;

  // Bits 15:10 are reserved and can never be accepted.
  localparam logic [NUM_EVENTS-1:0] EVT_VALID_MASK = 16'h03FF;

  typedef enum logic [1:0] {
    WARM_0,
    WARM_1,
    ARMED
  } warm_e;

endpackage

// File: rtl/event_trigger_out_debounce.sv
// Single pushbutton conditioner: 2-FF synchronizer, stability counter and the
// accepted (debounced) level, which powers up and resets to released (1).
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic clk1,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/event_trigger_out.sv
// Host event notifier: debounced button edges, threshold crossing and counter wrap
// become one-cycle trigger pulses with sticky status and a lost-event counter.
// Optional timestamp latch enabled by defining EVENT_TRIG_TIMESTAMP_EN.
module event_trigger_out
  import event_trig_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned LOST_W          = 16
) (
  input  logic                  clk1,
  input  logic                  reset,
  input  logic [3:0]            button,
  input  logic [31:0]           count_in,
  input  logic [31:0]           threshold,
  input  logic [15:0]           en_mask,
  input  logic [15:0]           ack,
  output logic [15:0]           trig_out,
  output logic [15:0]           status,
  output logic [LOST_W-1:0]     lost_cnt,
  output logic [31:0]           ts_latch
);

  logic [NUM_BUTTONS-1:0] deb;
  logic [NUM_BUTTONS-1:0] deb_d;
  logic [7:0]             btn_evt;
  logic [31:0]            cur;
  logic [31:0]            prev;
  warm_e                  warm;
  logic [NUM_EVENTS-1:0]  evt;
  logic [NUM_EVENTS-1:0]  acc;
  logic                   lost_hit;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk1  (clk1),
      .reset (reset),
      .raw   (button[i]),
      .level (deb[i])
    );
  end

  // Button edges are registered once more so press/release land DEBOUNCE_CYCLES+3 after sampling.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      deb_d   <= '1;
      btn_evt <= '0;
    end else begin
      deb_d   <= deb;
      btn_evt <= {deb & ~deb_d, deb_d & ~deb};
    end
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      cur  <= '0;
      prev <= '0;
      warm <= WARM_0;
    end else begin
      cur  <= count_in;
      prev <= cur;
      case (warm)
        WARM_0:  warm <= WARM_1;
        WARM_1:  warm <= ARMED;
        default: warm <= ARMED;
      endcase
    end
  end

  always_comb begin
    evt = '0;
    evt[EVT_RELEASE_LSB +: NUM_BUTTONS] = btn_evt[7:4];
    evt[EVT_PRESS_LSB   +: NUM_BUTTONS] = btn_evt[3:0];
    if (warm == ARMED) begin
      evt[EVT_CROSS] = (prev < threshold) && (cur >= threshold);
      evt[EVT_WRAP]  = prev[31] && !cur[31];
    end
  end

  assign acc      = evt & en_mask & EVT_VALID_MASK;
  assign lost_hit = |(acc & status & ~ack);

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      trig_out <= '0;
      status   <= '0;
      lost_cnt <= '0;
    end else begin
      trig_out <= acc;
      status   <= (status & ~ack) | acc;
      if (ack[ACK_LOST_CLR]) begin
        lost_cnt <= lost_hit ? LOST_W'(1) : '0;
      end else if (lost_hit && (lost_cnt != '1)) begin
        lost_cnt <= lost_cnt + LOST_W'(1);
      end
    end
  end

`ifdef EVENT_TRIG_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      ts_cnt   <= '0;
      ts_latch <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (|acc) begin
        ts_latch <= ts_cnt;
      end
    end
  end
`else
  assign ts_latch = '0;
`endif

endmodule

// File: tb/tb_event_trigger_out.sv
// Randomized bench for event_trigger_out with a run-length / sample-history model
// and directed scenarios whose expectations are hand-computed literals.
module tb_event_trigger_out;

  localparam int unsigned DEB = 8;

  logic        clk1 = 1'b0;
  logic        reset;
  logic [3:0]  button;
  logic [31:0] count_in;
  logic [31:0] threshold;
  logic [15:0] en_mask;
  logic [15:0] ack;
  logic [15:0] trig_out;
  logic [15:0] status;
  logic [15:0] lost_cnt;
  logic [31:0] ts_latch;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic        cmp_on = 1'b0;

  event_trigger_out #(
    .DEBOUNCE_CYCLES(DEB),
    .LOST_W(16)
  ) dut (
    .clk1      (clk1),
    .reset     (reset),
    .button    (button),
    .count_in  (count_in),
    .threshold (threshold),
    .en_mask   (en_mask),
    .ack       (ack),
    .trig_out  (trig_out),
    .status    (status),
    .lost_cnt  (lost_cnt),
    .ts_latch  (ts_latch)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_e;
  logic [15:0] sched [8];
  logic [3:0]  lastraw;
  logic [3:0]  mdeb;
  int unsigned run [4];
  logic [31:0] cur_s;
  logic [31:0] prev_s;
  int unsigned nsamp;
  logic [15:0] mtrig;
  logic [15:0] mstatus;
  logic [15:0] mlost;
  logic [31:0] mts;
`ifdef EVENT_TRIG_TIMESTAMP_EN
  logic [31:0] mcyc;
`endif

  task automatic model_clear();
    m_e = 0;
    for (int k = 0; k < 8; k++) sched[k] = '0;
    lastraw = 4'hF;
    mdeb    = 4'hF;
    for (int b = 0; b < 4; b++) run[b] = 0;
    cur_s = '0; prev_s = '0; nsamp = 0;
    mtrig = '0; mstatus = '0; mlost = '0; mts = '0;
`ifdef EVENT_TRIG_TIMESTAMP_EN
    mcyc = '0;
`endif
  endtask

  task automatic model_step();
    logic [15:0] evt;
    logic [15:0] acc;
    logic        lost_hit;
    evt = sched[m_e % 8];
    sched[m_e % 8] = '0;
    if (nsamp >= 2) begin
      if (prev_s < threshold && cur_s >= threshold) evt[8] = 1'b1;
      if (prev_s[31] && !cur_s[31]) evt[9] = 1'b1;
    end
    acc      = evt & en_mask & 16'h03FF;
    lost_hit = (acc & mstatus & ~ack) != 16'h0;
    mtrig    = acc;
    mstatus  = (mstatus & ~ack) | acc;
    if (ack[15]) mlost = lost_hit ? 16'd1 : 16'd0;
    else if (lost_hit && mlost != 16'hFFFF) mlost = mlost + 16'd1;
`ifdef EVENT_TRIG_TIMESTAMP_EN
    if (acc != 16'h0) mts = mcyc;
    mcyc = mcyc + 32'd1;
`endif
    prev_s = cur_s;
    cur_s  = count_in;
    if (nsamp < 2) nsamp++;
    // A new level is accepted once it has been seen DEB edges in a row; pulse 4 edges later.
    for (int b = 0; b < 4; b++) begin
      if (button[b] == lastraw[b]) begin
        if (run[b] < DEB) run[b]++;
      end else begin
        lastraw[b] = button[b];
        run[b] = 1;
      end
      if (run[b] == DEB && lastraw[b] != mdeb[b]) begin
        mdeb[b] = lastraw[b];
        sched[(m_e + 4) % 8][mdeb[b] ? b + 4 : b] = 1'b1;
      end
    end
    m_e++;
  endtask

  always @(posedge clk1 or posedge reset) begin
    if (reset) model_clear();
    else       model_step();
  end

  always @(posedge clk1) begin
    if (cmp_on) begin
      #1;
      chk("trig_out", 32'(trig_out), 32'(mtrig));
      chk("status",   32'(status),   32'(mstatus));
      chk("lost_cnt", 32'(lost_cnt), 32'(mlost));
      chk("ts_latch", ts_latch,      mts);
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_ack(input logic [15:0] v);
    @(negedge clk1) ack = v;
    @(negedge clk1) ack = '0;
  endtask

  initial begin
    reset = 1'b1; button = 4'hF; count_in = '0; threshold = 32'd100;
    en_mask = 16'hFFFF; ack = '0;
    repeat (3) @(negedge clk1);
    cmp_on = 1'b1;
    #1;
    chk("rst_trig", 32'(trig_out), 32'h0);
    chk("rst_status", 32'(status), 32'h0);
    chk("rst_lost", 32'(lost_cnt), 32'h0);
    @(negedge clk1) reset = 1'b0;
    repeat (4) @(negedge clk1);

    // button 0 press: pulse visible after the 11th edge following the sampling edge
    button = 4'hE;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk1); #1;
      chk("press_pulse", 32'(trig_out), (k == 12) ? 32'h1 : 32'h0);
    end
    chk("press_status", 32'(status), 32'h1);
    repeat (8) @(negedge clk1);
    button = 4'hF;
    repeat (14) @(negedge clk1);
    chk("release_status", 32'(status), 32'h11);
    pulse_ack(16'h0011);
    @(posedge clk1); #1;
    chk("ack_clear", 32'(status), 32'h0);

    // short glitch on button 1
    @(negedge clk1) button = 4'hD;
    repeat (5) @(negedge clk1);
    button = 4'hF;
    repeat (15) @(negedge clk1);
    chk("glitch_status", 32'(status), 32'h0);
    chk("glitch_lost", 32'(lost_cnt), 32'h0);

    // threshold crossing
    @(negedge clk1) count_in = 32'd98;
    @(negedge clk1) count_in = 32'd99;
    @(negedge clk1) count_in = 32'd100;
    @(posedge clk1); #1;
    chk("cross_early", 32'(trig_out), 32'h0);
    @(posedge clk1); #1;
    chk("cross_pulse", 32'(trig_out), 32'h100);
    @(negedge clk1) count_in = 32'd101;
    @(negedge clk1) count_in = 32'd99;
    @(negedge clk1) count_in = 32'd100;
    @(posedge clk1); @(posedge clk1); #1;
    chk("cross_again", 32'(trig_out), 32'h100);
    chk("cross_lost", 32'(lost_cnt), 32'h1);

    // event and ack on the same bit: event wins, no loss counted
    @(negedge clk1) count_in = 32'd99;
    @(negedge clk1) count_in = 32'd100;
    pulse_ack(16'h0100);
    @(posedge clk1); #1;
    chk("ev_ack_status", 32'(status), 32'h100);
    chk("ev_ack_lost", 32'(lost_cnt), 32'h1);
    pulse_ack(16'h0100);
    @(posedge clk1); #1;
    chk("ack_only", 32'(status), 32'h0);

    // wrap, masked then enabled
    @(negedge clk1) en_mask = 16'hFDFF;
    @(negedge clk1) count_in = 32'hFFFF_FFFF;
    @(negedge clk1) count_in = 32'h0;
    repeat (3) @(negedge clk1);
    chk("wrap_masked", 32'(status), 32'h0);
    en_mask = 16'hFFFF;
    @(negedge clk1) count_in = 32'hFFFF_FFFF;
    @(negedge clk1) count_in = 32'h0;
    @(posedge clk1); @(posedge clk1); #1;
    chk("wrap_pulse", 32'(trig_out), 32'h200);
    chk("wrap_status", 32'(status & 16'h0200), 32'h200);
    pulse_ack(16'h8300);
    @(posedge clk1); #1;
    chk("lost_clear", 32'(lost_cnt), 32'h0);
    chk("all_clear", 32'(status), 32'h0);

    // reset then timestamp of the first accepted event
    @(negedge clk1) reset = 1'b1;
    #1;
    chk("rst2_status", 32'(status), 32'h0);
    repeat (2) @(negedge clk1);
    reset = 1'b0;
    @(negedge clk1);
    @(negedge clk1) count_in = 32'd100;
    @(posedge clk1); @(posedge clk1); #1;
    chk("ts_trig", 32'(trig_out), 32'h100);
`ifdef EVENT_TRIG_TIMESTAMP_EN
    chk("ts_value", ts_latch, 32'd3);
`else
    chk("ts_value", ts_latch, 32'd0);
`endif

    // reset mid-debounce
    @(negedge clk1) button = 4'hE;
    repeat (4) @(negedge clk1);
    reset = 1'b1;
    #1;
    chk("rst_mid_deb", 32'(status), 32'h0);
    @(negedge clk1) button = 4'hF;
    @(negedge clk1) reset = 1'b0;
    repeat (15) @(negedge clk1);
    chk("no_evt_after_rst", 32'(status), 32'h0);

    // reset mid-pulse
    button = 4'hE;
    repeat (12) @(posedge clk1);
    #1;
    chk("pulse_before_rst", 32'(trig_out), 32'h1);
    @(negedge clk1) reset = 1'b1;
    #1;
    chk("rst_pulse_trig", 32'(trig_out), 32'h0);
    chk("rst_pulse_status", 32'(status), 32'h0);
    button = 4'hF;
    @(negedge clk1) reset = 1'b0;

    // randomized phase
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk1);
      reset = ($urandom_range(0, 999) == 0);
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 11) == 0) button[b] = ~button[b];
      case ($urandom_range(0, 5))
        0: count_in = $urandom;
        1: count_in = threshold + 32'($urandom_range(0, 4)) - 32'd2;
        2: count_in = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
        3: count_in = count_in + 32'd1;
        default: ;
      endcase
      ack = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0;
      if ($urandom_range(0, 99) == 0) en_mask = 16'($urandom);
      if ($urandom_range(0, 299) == 0)
        threshold = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(50, 200));
    end
    @(negedge clk1) begin reset = 1'b0; ack = '0; end
    repeat (20) @(negedge clk1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
